// File: rtl/wbu_mc.sv
// rtl/wbu_mc.sv - writeback merge of W-stage results and buffered MDU completions
//
// Purpose: drives the single register-file write port. The in-order W-stage
// result always wins; out-of-order MDU completions wait in a small FIFO and
// drain on W-stage bubbles. Load alignment/extension is done here.
// Optional feature macro: WBU_STARVE_GUARD_EN (forces a drain after
// STARVE_LIMIT consecutive starved cycles by raising stall_req).
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   valid_w, reg_write_w, rd_w W-stage slot qualifiers and destination
//   result_src_w               result select (ALU/load/PC+4/target/mul lo/hi)
//   load_control_w, byte_off_w load type (funct3) and low address bits
//   alu_result_w, read_data_w, pc_plus4_w, pc_target_w, mul_result_w  W-stage data
//   mdu_valid, mdu_rd, mdu_result, mdu_ready  MDU completion handshake
//   rf_we, rf_rd, rf_wd        registered register-file write port
//   mdu_pending                a live completion is still buffered
//   stall_req                  hold the W stage this cycle (starve guard only)

module wbu_mc #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_w,
  input  logic                         reg_write_w,
  input  logic [4:0]                   rd_w,
  input  logic [2:0]                   result_src_w,
  input  logic [2:0]                   load_control_w,
  input  logic [$clog2(XLEN/8)-1:0]    byte_off_w,
  input  logic [XLEN-1:0]              alu_result_w,
  input  logic [XLEN-1:0]              read_data_w,
  input  logic [XLEN-1:0]              pc_plus4_w,
  input  logic [XLEN-1:0]              pc_target_w,
  input  logic [2*XLEN-1:0]            mul_result_w,
  input  logic                         mdu_valid,
  input  logic [4:0]                   mdu_rd,
  input  logic [XLEN-1:0]              mdu_result,
  output logic                         mdu_ready,
  output logic                         rf_we,
  output logic [4:0]                   rf_rd,
  output logic [XLEN-1:0]              rf_wd,
  output logic                         mdu_pending,
  output logic                         stall_req
);

  localparam int PW = $clog2(DEPTH);

  if (!(XLEN == 32 || XLEN == 64) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      STARVE_LIMIT < 1) begin : g_param_check
    $error("wbu_mc: illegal parameter value");
  end

  // ---------------------------------------------------------------------------
  // Load formatting and W-stage result select
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] w_data;

  assign shifted = read_data_w >> {byte_off_w, 3'b000};

  always_comb begin
    load_data = '0;
    case (load_control_w)
      3'b000: load_data = XLEN'(signed'(shifted[7:0]));
      3'b001: load_data = XLEN'(signed'(shifted[15:0]));
      3'b010: load_data = XLEN'(signed'(shifted[31:0]));
      3'b011: load_data = (XLEN == 64) ? shifted : '0;
      3'b100: load_data = XLEN'(shifted[7:0]);
      3'b101: load_data = XLEN'(shifted[15:0]);
      3'b110: load_data = (XLEN == 64) ? XLEN'(shifted[31:0]) : '0;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    w_data = '0;
    case (result_src_w)
      3'b000: w_data = alu_result_w;
      3'b001: w_data = load_data;
      3'b010: w_data = pc_plus4_w;
      3'b011: w_data = pc_target_w;
      3'b100: w_data = mul_result_w[XLEN-1:0];
      3'b101: w_data = mul_result_w[2*XLEN-1:XLEN];
      default: w_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MDU completion FIFO
  // ---------------------------------------------------------------------------
  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  // A slot's live bit is cleared when it is popped, so unoccupied slots are
  // always dead and mdu_pending can simply OR the whole vector.
  logic [DEPTH-1:0] fifo_live;
  logic [PW:0]      wr_ptr, rd_ptr;
  logic [PW-1:0]    head_idx, tail_idx;

  logic empty, full, push, pop, pop_wr, head_live, push_live, pipe_wr;

  assign head_idx  = rd_ptr[PW-1:0];
  assign tail_idx  = wr_ptr[PW-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (tail_idx == head_idx);
  assign mdu_ready = !full;
  assign push      = mdu_valid && mdu_ready;
  assign head_live = fifo_live[head_idx];

  assign pipe_wr   = valid_w && reg_write_w && (rd_w != 5'd0) && !stall_req;
  assign pop       = !pipe_wr && !empty;
  assign pop_wr    = pop && head_live;
  // A completion arriving together with a W-stage write to the same rd is
  // older than that W-stage instruction, so it is stored already killed.
  assign push_live = (mdu_rd != 5'd0) && !(pipe_wr && (mdu_rd == rd_w));

  assign mdu_pending = |fifo_live;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail_idx]   <= mdu_rd;
      fifo_data[tail_idx] <= mdu_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_live <= '0;
    end else begin
      // Later assignments win: WAW kill, then pop clear, then push set.
      if (pipe_wr) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (fifo_rd[i] == rd_w) fifo_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        fifo_live[head_idx] <= 1'b0;
        rd_ptr              <= rd_ptr + (PW+1)'(1);
      end
      if (push) begin
        fifo_live[tail_idx] <= push_live;
        wr_ptr              <= wr_ptr + (PW+1)'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
`ifdef WBU_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // Depends only on registered state, so pipe_wr -> pop -> stall_req has no loop.
  assign stall_req = !empty && (starve_cnt == SW'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (head_live && pipe_wr) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  assign stall_req = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write port arbitration and output register
  // ---------------------------------------------------------------------------
  logic            wr_en;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_rd   = 5'd0;
    wr_data = '0;
    if (pipe_wr) begin
      wr_en   = 1'b1;
      wr_rd   = rd_w;
      wr_data = w_data;
    end else if (pop_wr) begin
      wr_en   = 1'b1;
      wr_rd   = fifo_rd[head_idx];
      wr_data = fifo_data[head_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we <= 1'b0;
      rf_rd <= 5'd0;
      rf_wd <= '0;
    end else begin
      rf_we <= wr_en;
      rf_rd <= wr_rd;
      rf_wd <= wr_data;
    end
  end

endmodule

// File: tb/tb_wbu_mc.sv
// tb/tb_wbu_mc.sv - directed self-checking bench for wbu_mc (XLEN=32, DEPTH=4)

module tb_wbu_mc;

  logic        clk;
  logic        reset;
  logic        valid_w;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [2:0]  result_src_w;
  logic [2:0]  load_control_w;
  logic [1:0]  byte_off_w;
  logic [31:0] alu_result_w;
  logic [31:0] read_data_w;
  logic [31:0] pc_plus4_w;
  logic [31:0] pc_target_w;
  logic [63:0] mul_result_w;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_result;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        mdu_pending;
  logic        stall_req;

  int n_assert = 0;
  int n_fail   = 0;

  wbu_mc #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .valid_w(valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_src_w(result_src_w), .load_control_w(load_control_w),
    .byte_off_w(byte_off_w), .alu_result_w(alu_result_w),
    .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w),
    .pc_target_w(pc_target_w), .mul_result_w(mul_result_w),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_result(mdu_result),
    .mdu_ready(mdu_ready), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .mdu_pending(mdu_pending), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] wd);
    chk({tag, ".we"}, 64'(rf_we), 64'(we));
    if (we) begin
      chk({tag, ".rd"}, 64'(rf_rd), 64'(rd));
      chk({tag, ".wd"}, 64'(rf_wd), 64'(wd));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] alu);
    valid_w      = 1'b1;
    reg_write_w  = 1'b1;
    rd_w         = rd;
    result_src_w = 3'b000;
    alu_result_w = alu;
  endtask

  task automatic bubble();
    valid_w     = 1'b0;
    reg_write_w = 1'b0;
    rd_w        = 5'd0;
  endtask

  task automatic mpush(input logic [4:0] rd, input logic [31:0] data);
    mdu_valid  = 1'b1;
    mdu_rd     = rd;
    mdu_result = data;
  endtask

  task automatic mnone();
    mdu_valid  = 1'b0;
    mdu_rd     = 5'd0;
    mdu_result = 32'h0;
  endtask

  task automatic load(input logic [2:0] lc, input logic [1:0] off);
    valid_w        = 1'b1;
    reg_write_w    = 1'b1;
    rd_w           = 5'd5;
    result_src_w   = 3'b001;
    load_control_w = lc;
    byte_off_w     = off;
  endtask

  initial begin
    reset          = 1'b1;
    bubble();
    mnone();
    result_src_w   = 3'b000;
    load_control_w = 3'b000;
    byte_off_w     = 2'd0;
    alu_result_w   = 32'h0;
    read_data_w    = 32'h80FF_1234;
    pc_plus4_w     = 32'h0000_0104;
    pc_target_w    = 32'h0000_2000;
    mul_result_w   = 64'h1111_2222_3333_4444;

    // Reset state
    tick();
    chk("rst.we", 64'(rf_we), 64'd0);
    chk("rst.rd", 64'(rf_rd), 64'd0);
    chk("rst.wd", 64'(rf_wd), 64'd0);
    chk("rst.ready", 64'(mdu_ready), 64'd1);
    chk("rst.pending", 64'(mdu_pending), 64'd0);
    chk("rst.stall", 64'(stall_req), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle.we", 64'(rf_we), 64'd0);

    // Load formatting
    load(3'b000, 2'd3); tick(); chk_wr("lb_off3", 1'b1, 5'd5, 32'hFFFF_FF80);
    load(3'b100, 2'd3); tick(); chk_wr("lbu_off3", 1'b1, 5'd5, 32'h0000_0080);
    load(3'b001, 2'd2); tick(); chk_wr("lh_off2", 1'b1, 5'd5, 32'hFFFF_80FF);
    load(3'b101, 2'd0); tick(); chk_wr("lhu_off0", 1'b1, 5'd5, 32'h0000_1234);
    load(3'b010, 2'd0); tick(); chk_wr("lw", 1'b1, 5'd5, 32'h80FF_1234);
    load(3'b011, 2'd0); tick(); chk_wr("ld_illegal", 1'b1, 5'd5, 32'h0);
    load(3'b111, 2'd0); tick(); chk_wr("lc111_illegal", 1'b1, 5'd5, 32'h0);
    // Other result sources
    wb(5'd6, 32'h0); result_src_w = 3'b010; tick(); chk_wr("src_pc4", 1'b1, 5'd6, 32'h0000_0104);
    result_src_w = 3'b011; tick(); chk_wr("src_tgt", 1'b1, 5'd6, 32'h0000_2000);
    result_src_w = 3'b100; tick(); chk_wr("src_mullo", 1'b1, 5'd6, 32'h3333_4444);
    result_src_w = 3'b101; tick(); chk_wr("src_mulhi", 1'b1, 5'd6, 32'h1111_2222);
    result_src_w = 3'b110; tick(); chk_wr("src_other", 1'b1, 5'd6, 32'h0);
    // rd_w == 0 and reg_write_w == 0 never write
    wb(5'd0, 32'h77); tick(); chk("rd0.we", 64'(rf_we), 64'd0);
    wb(5'd6, 32'h77); reg_write_w = 1'b0; tick(); chk("nowrite.we", 64'(rf_we), 64'd0);

    // MDU completion waits behind three W-stage writes, drains on the bubble
    wb(5'd3, 32'h33); mpush(5'd7, 32'h1234); tick();
    chk_wr("mdu_w1", 1'b1, 5'd3, 32'h33);
    chk("mdu_pend1", 64'(mdu_pending), 64'd1);
    mnone(); tick(); chk_wr("mdu_w2", 1'b1, 5'd3, 32'h33);
    tick(); chk_wr("mdu_w3", 1'b1, 5'd3, 32'h33);
    chk("mdu_pend3", 64'(mdu_pending), 64'd1);
    bubble(); tick(); chk_wr("mdu_drain", 1'b1, 5'd7, 32'h1234);
    chk("mdu_pend_after", 64'(mdu_pending), 64'd0);
    tick(); chk("mdu_idle.we", 64'(rf_we), 64'd0);

    // Fill to DEPTH, hold a fifth completion until space frees
    wb(5'd1, 32'h11);
    mpush(5'd10, 32'hA0); tick(); chk("full.ready1", 64'(mdu_ready), 64'd1);
    mpush(5'd11, 32'hA1); tick(); chk("full.ready2", 64'(mdu_ready), 64'd1);
    mpush(5'd12, 32'hA2); tick(); chk("full.ready3", 64'(mdu_ready), 64'd1);
    mpush(5'd13, 32'hA3); tick(); chk("full.ready4", 64'(mdu_ready), 64'd0);
    mpush(5'd14, 32'hA4); tick();
    chk("full.hold_ready", 64'(mdu_ready), 64'd0);
    chk_wr("full.wstage", 1'b1, 5'd1, 32'h11);
    bubble(); tick();
    chk_wr("full.pop10", 1'b1, 5'd10, 32'hA0);
    chk("full.ready_after_pop", 64'(mdu_ready), 64'd1);
    tick();
    chk_wr("full.pop11", 1'b1, 5'd11, 32'hA1);
    mnone();
    tick(); chk_wr("full.pop12", 1'b1, 5'd12, 32'hA2);
    tick(); chk_wr("full.pop13", 1'b1, 5'd13, 32'hA3);
    chk("full.pend13", 64'(mdu_pending), 64'd1);
    tick(); chk_wr("full.pop14", 1'b1, 5'd14, 32'hA4);
    chk("full.pend_empty", 64'(mdu_pending), 64'd0);
    tick(); chk("full.idle", 64'(rf_we), 64'd0);

    // WAW kill of a buffered entry
    wb(5'd2, 32'h22); mpush(5'd9, 32'h99); tick();
    chk("waw.pend_buf", 64'(mdu_pending), 64'd1);
    mnone(); wb(5'd9, 32'hAA); tick();
    chk_wr("waw.wstage", 1'b1, 5'd9, 32'hAA);
    chk("waw.pend_killed", 64'(mdu_pending), 64'd0);
    bubble(); tick();
    chk("waw.dead_pop.we", 64'(rf_we), 64'd0);
    chk("waw.ready", 64'(mdu_ready), 64'd1);

    // Same-cycle push and W-stage write to the same rd
    wb(5'd4, 32'h4A); mpush(5'd4, 32'h44); tick();
    chk_wr("same.wstage", 1'b1, 5'd4, 32'h4A);
    chk("same.pend", 64'(mdu_pending), 64'd0);
    mnone(); bubble(); tick();
    chk("same.dead_pop.we", 64'(rf_we), 64'd0);

    // mdu_rd == 0 push never writes
    wb(5'd6, 32'h66); mpush(5'd0, 32'h55); tick();
    chk_wr("rd0push.wstage", 1'b1, 5'd6, 32'h66);
    chk("rd0push.pend", 64'(mdu_pending), 64'd0);
    mnone(); bubble(); tick();
    chk("rd0push.pop.we", 64'(rf_we), 64'd0);
    tick();
    chk("rd0push.idle.we", 64'(rf_we), 64'd0);

`ifdef WBU_STARVE_GUARD_EN
    // Starvation guard: one live entry, W stage writing every cycle
    wb(5'd8, 32'h88); mpush(5'd20, 32'hBEEF); tick();
    mnone();
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("starve.no_stall", 64'(stall_req), 64'd0);
    end
    tick();
    chk("starve.stall", 64'(stall_req), 64'd1);
    tick();
    chk_wr("starve.drain", 1'b1, 5'd20, 32'hBEEF);
    chk("starve.stall_clear", 64'(stall_req), 64'd0);
    tick();
    chk_wr("starve.resume", 1'b1, 5'd8, 32'h88);
    bubble(); tick();
`endif

    // Asynchronous reset with three buffered entries
    wb(5'd3, 32'h31);
    mpush(5'd15, 32'hC0); tick();
    mpush(5'd16, 32'hC1); tick();
    mpush(5'd17, 32'hC2); tick();
    mnone();
    chk("arst.pend_before", 64'(mdu_pending), 64'd1);
    chk("arst.we_before", 64'(rf_we), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst.we", 64'(rf_we), 64'd0);
    chk("arst.rd", 64'(rf_rd), 64'd0);
    chk("arst.wd", 64'(rf_wd), 64'd0);
    chk("arst.pend", 64'(mdu_pending), 64'd0);
    chk("arst.ready", 64'(mdu_ready), 64'd1);
    chk("arst.stall", 64'(stall_req), 64'd0);
    bubble();
    tick();
    reset = 1'b0;
    tick();
    chk("arst.discard1.we", 64'(rf_we), 64'd0);
    tick();
    chk("arst.discard2.we", 64'(rf_we), 64'd0);
    chk("arst.pend_after", 64'(mdu_pending), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
